// File: rtl/regfile_param.sv
// Parameterised register file with an r0-hardwired-zero convention and a
// sequential clear sweep. Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_param #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Clear,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    output logic [WIDTH-1:0]  ReadData1,
    output logic [WIDTH-1:0]  ReadData2,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [WIDTH-1:0]  WriteData,
    input  logic              RegWrite,
    output logic              Ready,
    output logic              dbgState
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } stateT;

    stateT             state, nextState;
    logic [ADDR_W-1:0] ptr, nextPtr;
    logic [WIDTH-1:0]  regs [DEPTH];
    logic              writeEn;
    logic              sweepEn;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= CLEAR;
            ptr   <= ADDR_W'(1);
        end else begin
            state <= nextState;
            ptr   <= nextPtr;
        end
    end

    // Sweep ends on the edge that zeroes the top register; ptr never wraps.
    always_comb begin
        nextState = state;
        nextPtr   = ptr;
        writeEn   = 1'b0;
        sweepEn   = 1'b0;
        case (state)
            CLEAR: begin
                if (Clear) begin
                    nextPtr = ADDR_W'(1);
                end else begin
                    sweepEn = 1'b1;
                    if (&ptr) nextState = RUN;
                    else      nextPtr   = ptr + ADDR_W'(1);
                end
            end
            RUN: begin
                if (Clear) begin
                    nextState = CLEAR;
                    nextPtr   = ADDR_W'(1);
                end else begin
                    writeEn = RegWrite && (WriteRegister != '0) && !Reset;
                end
            end
            default: nextState = CLEAR;
        endcase
    end

    // Register 0 is never stored; it is forced to zero on the read side.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            if (sweepEn)      regs[ptr]           <= '0;
            else if (writeEn) regs[WriteRegister] <= WriteData;
        end
    end

    function automatic logic [WIDTH-1:0] readPort(input logic [ADDR_W-1:0] addr);
        logic [WIDTH-1:0] data;
        if (state != RUN || addr == '0) begin
            data = '0;
        end else begin
`ifdef REGFILE_BYPASS_EN
            if (writeEn && addr == WriteRegister) data = WriteData;
            else                                  data = regs[addr];
`else
            data = regs[addr];
`endif
        end
        return data;
    endfunction

    always_comb begin
        ReadData1 = readPort(ReadRegister1);
        ReadData2 = readPort(ReadRegister2);
    end

    assign Ready    = (state == RUN);
    assign dbgState = state;

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: a default 32x32 instance and a small
// WIDTH=8/ADDR_W=2 instance sharing one clock.
module tb_regfile_param;

    logic        Clk;
    logic        Reset, Clear, RegWrite, Ready, dbgState;
    logic [4:0]  ReadRegister1, ReadRegister2, WriteRegister;
    logic [31:0] ReadData1, ReadData2, WriteData;

    logic       sReset, sClear, sRegWrite, sReady, sDbgState;
    logic [1:0] sRead1, sRead2, sWriteReg;
    logic [7:0] sData1, sData2, sWriteData;

    int checks   = 0;
    int failures = 0;

    regfile_param dut (
        .Clk(Clk), .Reset(Reset), .Clear(Clear),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .WriteRegister(WriteRegister), .WriteData(WriteData),
        .RegWrite(RegWrite), .Ready(Ready), .dbgState(dbgState)
    );

    regfile_param #(.WIDTH(8), .ADDR_W(2)) dutSmall (
        .Clk(Clk), .Reset(sReset), .Clear(sClear),
        .ReadRegister1(sRead1), .ReadRegister2(sRead2),
        .ReadData1(sData1), .ReadData2(sData2),
        .WriteRegister(sWriteReg), .WriteData(sWriteData),
        .RegWrite(sRegWrite), .Ready(sReady), .dbgState(sDbgState)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic write(input logic [4:0] addr, input logic [31:0] data);
        WriteRegister = addr;
        WriteData     = data;
        RegWrite      = 1'b1;
        tick();
        RegWrite      = 1'b0;
    endtask

    // Expects CLEAR for n edges with zero reads, then RUN.
    task automatic expectSweep(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            ReadRegister1 = 5'($urandom_range(0, 31));
            ReadRegister2 = 5'($urandom_range(1, 31));
            #1;
            check({tag, "_ready_low"}, {31'b0, Ready}, 32'd0);
            check({tag, "_rd1_zero"}, ReadData1, 32'd0);
            check({tag, "_rd2_zero"}, ReadData2, 32'd0);
            tick();
        end
        check({tag, "_ready_high"}, {31'b0, Ready}, 32'd1);
        check({tag, "_state_run"}, {31'b0, dbgState}, 32'd1);
    endtask

    initial begin
        Reset = 1'b1; Clear = 1'b0; RegWrite = 1'b0;
        ReadRegister1 = 5'd5; ReadRegister2 = 5'd6;
        WriteRegister = 5'd0; WriteData = 32'd0;
        sReset = 1'b1; sClear = 1'b0; sRegWrite = 1'b0;
        sRead1 = 2'd0; sRead2 = 2'd0; sWriteReg = 2'd0; sWriteData = 8'd0;

        // Reset held three edges, write attempts ignored.
        RegWrite = 1'b1; WriteRegister = 5'd5; WriteData = 32'hFFFF_FFFF;
        repeat (3) tick();
        RegWrite = 1'b0;
        check("reset_ready", {31'b0, Ready}, 32'd0);
        check("reset_state", {31'b0, dbgState}, 32'd0);
        check("reset_rd1", ReadData1, 32'd0);
        Reset = 1'b0;
        expectSweep("initial_sweep", 31);

        ReadRegister1 = 5'd7; #1;
        check("swept_r7", ReadData1, 32'd0);

        write(5'd7, 32'hDEADBEEF);
        ReadRegister1 = 5'd7; ReadRegister2 = 5'd7; #1;
        check("r7_port1", ReadData1, 32'hDEADBEEF);
        check("r7_port2", ReadData2, 32'hDEADBEEF);

        write(5'd0, 32'h0000_1234);
        ReadRegister1 = 5'd0; ReadRegister2 = 5'd0; #1;
        check("r0_port1", ReadData1, 32'd0);
        check("r0_port2", ReadData2, 32'd0);

        // Same-cycle write/read of r9.
        write(5'd9, 32'h1111_1111);
        WriteRegister = 5'd9; WriteData = 32'hA5A5A5A5; RegWrite = 1'b1;
        ReadRegister1 = 5'd9; ReadRegister2 = 5'd7; #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass_r9", ReadData1, 32'hA5A5A5A5);
`else
        check("nobypass_r9", ReadData1, 32'h1111_1111);
`endif
        check("bypass_other_port", ReadData2, 32'hDEADBEEF);
        tick();
        RegWrite = 1'b0; #1;
        check("r9_after_edge", ReadData1, 32'hA5A5A5A5);

        for (int i = 1; i < 32; i++) write(5'(i), 32'(i));
        ReadRegister1 = 5'd3; ReadRegister2 = 5'd31; #1;
        check("fill_r3", ReadData1, 32'd3);
        check("fill_r31", ReadData2, 32'd31);
        ReadRegister1 = 5'd17; ReadRegister2 = 5'd17; #1;
        check("fill_r17_p1", ReadData1, 32'd17);
        check("fill_r17_p2", ReadData2, 32'd17);

        // Clear with a simultaneous write to r3: write must be dropped.
        Clear = 1'b1; RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 32'hCAFE_F00D;
        tick();
        Clear = 1'b0;
        check("clear_state", {31'b0, dbgState}, 32'd0);
        expectSweep("clear_sweep", 31);
        RegWrite = 1'b0;
        for (int i = 1; i < 32; i++) begin
            ReadRegister1 = 5'(i); ReadRegister2 = 5'(32 - i); #1;
            check("cleared_p1", ReadData1, 32'd0);
            check("cleared_p2", ReadData2, 32'd0);
        end

        // Reset mid-sweep at ptr=15 restarts the full sweep.
        write(5'd4, 32'h4444_4444);
        Clear = 1'b1; tick(); Clear = 1'b0;
        repeat (14) tick();
        check("mid_sweep_ready", {31'b0, Ready}, 32'd0);
        Reset = 1'b1; tick(); Reset = 1'b0;
        expectSweep("reset_restart", 31);

        // Clear during a sweep restarts it; Clear+Reset behaves as reset.
        Clear = 1'b1; tick(); Clear = 1'b0;
        repeat (5) tick();
        Clear = 1'b1; Reset = 1'b1; tick(); Reset = 1'b0;
        tick(); Clear = 1'b0;
        expectSweep("clear_restart", 31);

        write(5'd12, 32'h0BAD_CAFE);
        Reset = 1'b1; tick(); Reset = 1'b0;
        ReadRegister1 = 5'd12; #1;
        check("reset_in_run_rd", ReadData1, 32'd0);
        check("reset_in_run_ready", {31'b0, Ready}, 32'd0);
        expectSweep("run_reset_sweep", 31);
        ReadRegister1 = 5'd12; #1;
        check("r12_swept", ReadData1, 32'd0);

        // Small instance: 3-edge sweep.
        tick(); sReset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("small_ready_low", {31'b0, sReady}, 32'd0);
            tick();
        end
        check("small_ready_high", {31'b0, sReady}, 32'd1);
        sWriteReg = 2'd3; sWriteData = 8'hFF; sRegWrite = 1'b1;
        tick();
        sRegWrite = 1'b0;
        sRead1 = 2'd3; sRead2 = 2'd2; #1;
        check("small_r3", {24'b0, sData1}, 32'h0000_00FF);
        check("small_r2", {24'b0, sData2}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data width of each register in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, giving the address width; depth is DEPTH = 2**ADDR_W, legal ADDR_W 1..6.
REQ-003 The block SHALL have port Clk, input, 1 bit: the only clock; all state updates occur on the positive edge.
REQ-004 The block SHALL have port Reset, input, 1 bit: reset, synchronous and active-high, sampled on the Clk rising edge.
REQ-005 The block SHALL have port Clear, input, 1 bit: a synchronous request to zero all registers via the sweep.
REQ-006 The block SHALL have port ReadRegister1, input, ADDR_W bits: the read port 1 address.
REQ-007 The block SHALL have port ReadRegister2, input, ADDR_W bits: the read port 2 address.
REQ-008 The block SHALL have port ReadData1, output, WIDTH bits: the read port 1 data (asynchronous).
REQ-009 The block SHALL have port ReadData2, output, WIDTH bits: the read port 2 data (asynchronous).
REQ-010 The block SHALL have port WriteRegister, input, ADDR_W bits: the write address.
REQ-011 The block SHALL have port WriteData, input, WIDTH bits: the write data.
REQ-012 The block SHALL have port RegWrite, input, 1 bit: the write enable, active high.
REQ-013 The block SHALL have port Ready, output, 1 bit: high when the block is in RUN and accepts writes.

Function
REQ-014 The block SHALL implement a two-state FSM with states CLEAR (sweep in progress) and RUN (normal operation).
REQ-015 In CLEAR, the block SHALL zero register ptr on each rising edge, where ptr is an internal counter of ADDR_W bits, and then increment ptr.
REQ-016 When the edge that zeroes register DEPTH-1 occurs, the FSM SHALL move to RUN, so Ready rises DEPTH-1 edges after the sweep starts.
REQ-017 In CLEAR, the block SHALL ignore RegWrite.
REQ-018 In CLEAR, ReadData1 and ReadData2 SHALL read as 0 regardless of address.
REQ-019 In RUN, if RegWrite=1 and WriteRegister!=0, the block SHALL store WriteData into that register on the rising edge.
REQ-020 The stored value SHALL be visible on the read ports after that edge.
REQ-021 Register 0 SHALL always read as 0.
REQ-022 Writes to register 0 SHALL be discarded, and register 0 SHALL be excluded from the sweep (ptr starts at 1).
REQ-023 Read ports SHALL be combinational with zero latency, independent of each other.
REQ-024 Both read ports SHALL return identical data when both addresses are the same.
REQ-025 If Clear=1 at an edge in RUN, the FSM SHALL enter CLEAR with ptr=1, and any RegWrite in the same cycle SHALL be discarded.
REQ-026 If Clear=1 at an edge in CLEAR, the sweep SHALL restart with ptr=1.
REQ-027 If Clear and Reset are both high, Reset SHALL take precedence; the outcome is the same state.
REQ-028 ptr SHALL NOT wrap past DEPTH-1; the transition to RUN occurs on the edge that zeroes register DEPTH-1.
REQ-029 For ADDR_W=1, the sweep SHALL take exactly one edge.

Reset
REQ-030 If Reset=1 at a rising edge, the block SHALL set state=CLEAR, ptr=1 and Ready=0.
REQ-031 While Reset is held high, the block SHALL hold state=CLEAR and ptr=1, with no sweep progress.
REQ-032 The sweep SHALL begin at the first edge with Reset=0.
REQ-033 Reset in the middle of a sweep or in RUN SHALL restart the sweep.
REQ-034 During and after reset, ReadData1 and ReadData2 SHALL be 0 until Ready=1; Ready's reset value SHALL be 0.

Configuration
REQ-035 When macro REGFILE_BYPASS_EN is defined, in RUN with RegWrite=1 and WriteRegister!=0, any read port whose address equals WriteRegister SHALL return WriteData combinationally in the same cycle.
REQ-036 When REGFILE_BYPASS_EN is not defined, a read port in the same-address case SHALL return the old stored value until the edge.
REQ-037 The register 0 and CLEAR-state zero rules SHALL hold in both configurations.

Verification
REQ-038 Reset high 3 edges, then low with ADDR_W=5 -> Ready=0 for 31 edges and 1 after the 31st; all reads during the sweep return 0.
REQ-039 In RUN, write 0xDEADBEEF to r7, then read r7 on both ports -> both 0xDEADBEEF the cycle after the edge; a write of 0x1234 to r0 -> r0 still reads 0.
REQ-040 In RUN, set WriteRegister=9, WriteData=0xA5A5A5A5, RegWrite=1, ReadRegister1=9 before the edge -> with macro, 0xA5A5A5A5; without macro, the previous value.
REQ-041 Fill r1..r31 with their index, pulse Clear with RegWrite=1 to r3 in the same cycle -> Ready=0 for 31 edges, r3 is not written, and all registers read 0 afterwards.
REQ-042 Assert Reset when ptr=15 during a sweep -> the sweep restarts at ptr=1 and Ready rises 31 edges after Reset deasserts.
REQ-043 With WIDTH=8 and ADDR_W=2, write 0xFF to r3, then read -> 0xFF; Ready rises 3 edges after reset.
